// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the uart_tx sharing arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int UART_BYTE_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first set bit of mask scanning upward from ptr, wrapping at N.
module rr_picker #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] id
);

  logic [IDW-1:0] idx;

  // Walk from the farthest offset down so the closest hit to ptr is written last.
  always_comb begin
    any = 1'b0;
    id  = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (mask[idx]) begin
        any = 1'b1;
        id  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers with per-byte round-robin and packet lock.
//  state | meaning
//  IDLE  | wait for transmitter idle, pick a requester, launch its byte
//  SEND  | byte on the line; wait for Tx_Done or watchdog expiry
//  GAP   | forced idle clocks between frames
import uart_pkg::*;

module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int GAP_CLKS  = 0,
  parameter int WDOG_CLKS = 20000
) (
  input  logic                            i_Clock,
  input  logic                            i_Rst_n,
  input  logic [NUM_REQ-1:0]              i_Req_Valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0]  i_Req_Byte,
  input  logic [NUM_REQ-1:0]              i_Req_Last,
  output logic [NUM_REQ-1:0]              o_Req_Ready,
  output logic [NUM_REQ-1:0]              o_Req_Done,
  output logic                            o_Tx_DV,
  output logic [UART_BYTE_W-1:0]          o_Tx_Byte,
  input  logic                            i_Tx_Active,
  input  logic                            i_Tx_Done,
  output logic                            o_Busy,
  output logic [$clog2(NUM_REQ)-1:0]      o_Grant_Id,
  output logic                            o_Err
);

  localparam int IDW     = $clog2(NUM_REQ);
  localparam int CNT_MAX = (WDOG_CLKS > GAP_CLKS) ? WDOG_CLKS : GAP_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(WDOG_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CLKS - 1);

  arb_state_t           state;
  logic [IDW-1:0]       ptr;
  logic                 lock;
  logic [IDW-1:0]       lock_id;
  logic [IDW-1:0]       cur_id;
  logic [CNT_W-1:0]     cnt;

  logic [NUM_REQ-1:0]   cand;
  logic                 pick_any;
  logic [IDW-1:0]       pick_id;
  logic [UART_BYTE_W-1:0] win_byte;
  logic                 win_last;

  // While a packet is open only its owner may compete.
  assign cand     = lock ? (i_Req_Valid & (NUM_REQ'(1) << lock_id)) : i_Req_Valid;
  assign win_byte = i_Req_Byte[{pick_id, 3'b000} +: UART_BYTE_W];
  assign win_last = i_Req_Last[pick_id];

  rr_picker #(.N(NUM_REQ), .IDW(IDW)) u_picker (
    .mask (cand),
    .ptr  (ptr),
    .any  (pick_any),
    .id   (pick_id)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      lock        <= 1'b0;
      lock_id     <= '0;
      cur_id      <= '0;
      cnt         <= '0;
      o_Tx_DV     <= 1'b0;
      o_Tx_Byte   <= '0;
      o_Req_Ready <= '0;
      o_Req_Done  <= '0;
      o_Busy      <= 1'b0;
      o_Grant_Id  <= '0;
      o_Err       <= 1'b0;
    end else begin
      o_Tx_DV     <= 1'b0;
      o_Req_Ready <= '0;
      o_Req_Done  <= '0;
      o_Err       <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_Tx_Active && pick_any) begin
            o_Tx_DV     <= 1'b1;
            o_Tx_Byte   <= win_byte;
            o_Req_Ready <= NUM_REQ'(1) << pick_id;
            o_Grant_Id  <= pick_id;
            cur_id      <= pick_id;
            cnt         <= WDOG_LOAD;
            state       <= SEND;
            o_Busy      <= 1'b1;
            if (win_last) begin
              lock <= 1'b0;
              ptr  <= (pick_id == IDW'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
            end else begin
              lock    <= 1'b1;
              lock_id <= pick_id;
            end
          end
        end
        SEND: begin
          if (i_Tx_Done) begin
            o_Req_Done <= NUM_REQ'(1) << cur_id;
            if (GAP_CLKS > 0) begin
              state <= GAP;
              cnt   <= GAP_LOAD;
            end else begin
              state  <= IDLE;
              o_Busy <= 1'b0;
            end
          end else if (cnt == '0) begin
            // Transmitter never finished: drop the packet so others are not starved.
            o_Err  <= 1'b1;
            lock   <= 1'b0;
            state  <= IDLE;
            o_Busy <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state  <= IDLE;
            o_Busy <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx and queue-driven requesters.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int GAP   = 5;
  localparam int WDOG  = 50;
  localparam int FRAME = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_byte;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] req_done;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic          tx_done;
  logic          busy;
  logic [1:0]    grant_id;
  logic          err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CLKS(GAP), .WDOG_CLKS(WDOG)) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Req_Valid (req_valid),
    .i_Req_Byte  (req_byte),
    .i_Req_Last  (req_last),
    .o_Req_Ready (req_ready),
    .o_Req_Done  (req_done),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Busy      (busy),
    .o_Grant_Id  (grant_id),
    .o_Err       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int model_cnt = 0;
  int drop_tick = 0;
  int err_cnt = 0;
  int err_tick = 0;
  bit stub = 1'b0;

  logic [8:0] rq_mem [NR][8];
  int rq_head [NR];
  int rq_tail [NR];

  int line_byte[$];
  int line_id[$];
  int line_tick[$];
  int ready_log[$];
  int done_log[$];
  int done_tick[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int r = 0; r < NR; r++) begin
      if (rq_head[r] < rq_tail[r]) begin
        req_valid[r]        = 1'b1;
        req_byte[r*8 +: 8]  = rq_mem[r][rq_head[r]][7:0];
        req_last[r]         = rq_mem[r][rq_head[r]][8];
      end else begin
        req_valid[r]        = 1'b0;
        req_byte[r*8 +: 8]  = 8'h00;
        req_last[r]         = 1'b0;
      end
    end
  endtask

  task automatic push_req(input int r, input logic [7:0] b, input logic l);
    rq_mem[r][rq_tail[r]] = {l, b};
    rq_tail[r]++;
    drive_reqs();
  endtask

  task automatic clear_logs();
    line_byte.delete(); line_id.delete(); line_tick.delete();
    ready_log.delete(); done_log.delete(); done_tick.delete();
    err_cnt = 0;
    for (int r = 0; r < NR; r++) begin
      rq_head[r] = 0;
      rq_tail[r] = 0;
    end
    drive_reqs();
  endtask

  // One clock: observe DUT at the falling edge, then advance uart_tx model and requesters.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (tx_dv) begin
      check_val("dv_into_busy", {31'd0, tx_active}, 32'd0);
      line_byte.push_back(int'(tx_byte));
      line_id.push_back(int'(grant_id));
      line_tick.push_back(cyc);
    end
    for (int r = 0; r < NR; r++) begin
      if (req_ready[r]) begin
        ready_log.push_back(r);
        if (rq_head[r] < rq_tail[r]) rq_head[r]++;
      end
      if (req_done[r]) begin
        done_log.push_back(r);
        done_tick.push_back(cyc);
      end
    end
    if (err) begin
      err_cnt++;
      err_tick = cyc;
    end
    tx_done = 1'b0;
    if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0) begin
        tx_active = 1'b0;
        tx_done   = 1'b1;
        drop_tick = cyc;
      end
    end
    if (tx_dv && !stub) begin
      tx_active = 1'b1;
      model_cnt = FRAME;
    end
    drive_reqs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tx_active = 1'b0;
    tx_done = 1'b0;
    model_cnt = 0;
    clear_logs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_dv(input int n, input int budget, input string tag);
    int k = 0;
    while (line_byte.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_val(tag, {31'd0, line_byte.size() >= n}, 32'd1);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (done_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_val(tag, {31'd0, done_log.size() >= n}, 32'd1);
  endtask

  task automatic check_line(input int i, input int exp_byte, input int exp_id, input string tag);
    if (line_byte.size() > i) begin
      check_val({tag, "_byte"}, line_byte[i], exp_byte);
      check_val({tag, "_id"}, line_id[i], exp_id);
    end else begin
      check_val({tag, "_missing"}, line_byte.size(), i + 1);
    end
  endtask

  function automatic int count_id(input int q[$], input int id);
    int c = 0;
    foreach (q[i]) if (q[i] == id) c++;
    return c;
  endfunction

  int exp3_b[6] = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h52, 8'h50};
  int exp3_i[6] = '{0, 1, 1, 1, 2, 0};

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_byte = '0;
    req_last = '0;
    tx_active = 1'b0;
    tx_done = 1'b0;
    for (int r = 0; r < NR; r++) begin
      rq_head[r] = 0;
      rq_tail[r] = 0;
    end

    // 1: reset in the middle of a frame, transmitter still busy at release
    do_reset();
    for (int r = 0; r < NR; r++) push_req(r, 8'(8'hB0 + r), 1'b1);
    repeat (10) tick();
    check_val("t1_frame_running", {31'd0, tx_active}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("t1_outs_in_rst", {11'd0, tx_dv, req_ready, req_done, busy, err, grant_id, tx_byte}, 32'd0);
    clear_logs();
    for (int r = 0; r < NR; r++) push_req(r, 8'(8'hB0 + r), 1'b1);
    repeat (3) tick();
    check_val("t1_outs_hold_rst", {11'd0, tx_dv, req_ready, req_done, busy, err, grant_id, tx_byte}, 32'd0);
    rst_n = 1'b1;
    wait_dv(1, 200, "t1_dv_timeout");
    check_line(0, 8'hB0, 0, "t1_first");
    if (line_tick.size() > 0) check_val("t1_dv_after_drop", line_tick[0], drop_tick + 1);
    check_val("t1_no_done_stale", done_log.size(), 0);

    // 2: all four valid, round-robin per byte
    do_reset();
    for (int r = 0; r < NR; r++) begin
      push_req(r, 8'(8'hA0 + r), 1'b1);
      push_req(r, 8'(8'hA0 + r), 1'b1);
    end
    wait_dv(5, 400, "t2_dv_timeout");
    for (int i = 0; i < 5; i++) check_line(i, 8'hA0 + (i % 4), i % 4, "t2_line");
    wait_done(4, 100, "t2_done_timeout");
    for (int i = 0; i < 4; i++) if (done_log.size() > i) check_val("t2_done_order", done_log[i], i);
    for (int i = 0; i < 5; i++) if (ready_log.size() > i) check_val("t2_ready_order", ready_log[i], i % 4);
    check_val("t2_no_err", err_cnt, 0);

    // 3: r1 packet of three bytes stays contiguous
    do_reset();
    push_req(0, 8'h5A, 1'b1);
    wait_dv(1, 50, "t3_prime_timeout");
    push_req(0, 8'h50, 1'b1);
    push_req(1, 8'h11, 1'b0);
    push_req(1, 8'h22, 1'b0);
    push_req(1, 8'h33, 1'b1);
    push_req(2, 8'h52, 1'b1);
    wait_dv(6, 600, "t3_dv_timeout");
    for (int i = 0; i < 6; i++) check_line(i, exp3_b[i], exp3_i[i], "t3_line");

    // 4: transmitter never finishes; watchdog aborts and clears the lock
    do_reset();
    stub = 1'b1;
    push_req(1, 8'h77, 1'b0);
    push_req(2, 8'h62, 1'b1);
    wait_dv(1, 50, "t4_dv_timeout");
    check_line(0, 8'h77, 1, "t4_first");
    begin
      int k = 0;
      while (err_cnt == 0 && k < 100) begin
        tick();
        k++;
      end
    end
    check_val("t4_err_once", err_cnt, 1);
    if (line_tick.size() > 0) check_val("t4_err_time", err_tick - line_tick[0], WDOG);
    check_val("t4_no_done", done_log.size(), 0);
    wait_dv(2, 20, "t4_next_timeout");
    check_line(1, 8'h62, 2, "t4_next");
    if (line_tick.size() > 1) check_val("t4_next_time", line_tick[1], err_tick + 1);
    stub = 1'b0;

    // 5: inter-frame gap with a single requester
    do_reset();
    push_req(0, 8'h5E, 1'b1);
    push_req(0, 8'h5F, 1'b1);
    wait_done(1, 100, "t5_done_timeout");
    check_val("t5_busy_gap0", {31'd0, busy}, 32'd1);
    for (int i = 1; i < GAP; i++) begin
      tick();
      check_val("t5_busy_gap", {31'd0, busy}, 32'd1);
    end
    tick();
    check_val("t5_idle_busy", {31'd0, busy}, 32'd0);
    wait_dv(2, 10, "t5_dv2_timeout");
    if (line_tick.size() > 1 && done_tick.size() > 0)
      check_val("t5_gap_len", line_tick[1] - done_tick[0], GAP + 1);
    check_line(1, 8'h5F, 0, "t5_second");

    // 6: r3 withdraws before it is served; pointer would otherwise favour it
    do_reset();
    push_req(2, 8'h62, 1'b1);
    wait_dv(1, 50, "t6_prime_timeout");
    push_req(0, 8'h40, 1'b1);
    push_req(3, 8'h43, 1'b1);
    repeat (5) tick();
    rq_head[3] = rq_tail[3];
    drive_reqs();
    wait_dv(2, 200, "t6_dv_timeout");
    check_line(1, 8'h40, 0, "t6_second");
    wait_done(2, 100, "t6_done_timeout");
    check_val("t6_r3_ready", count_id(ready_log, 3), 0);
    check_val("t6_r3_done", count_id(done_log, 3), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
